ifu: RTL and testbench
======================

# ifu

Instruction fetch unit for the npc single-cycle RV32 core. Owns the fetch PC, issues one word read per instruction to the instruction memory port over a valid/ready request and response bus, and holds the fetched word stable for the decode/execute datapath until it is accepted. On acceptance it samples the core's next PC (`pc + 4`, or a jal/jalr target), so the core's PC register and fixed-instruction input are replaced by this handshake.

## Interface
Parameters:
- `RESET_PC`, 32'h80000000: first fetch address after reset.
- `NOP_INST`, 32'h00000013: word driven on `inst` when a fetch faults.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `next_pc`  in  32  next fetch address from the core; sampled only on an output handshake.
- `inst_ready`  in  1  core consumes the held instruction this cycle.
- `inst_valid`  out  1  `inst`, `pc`, `inst_fault` are valid.
- `inst`  out  32  fetched instruction word.
- `pc`  out  32  address of `inst`.
- `inst_fault`  out  1  fetch error or misaligned `next_pc`; `inst` = `NOP_INST`.
- `mem_req_valid`  out  1  read request.
- `mem_req_addr`  out  32  word address (equals `pc`).
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_resp_valid`  in  1  read data returned.
- `mem_resp_data`  in  32  read data.
- `mem_resp_err`  in  1  bus error, qualified by `mem_resp_valid`.

## Operation
- FSM states: S_REQ, S_WAIT, S_OUT.
- S_REQ: `mem_req_valid`=1, `mem_req_addr`=`pc`. If `mem_req_ready` → S_WAIT; otherwise hold. Address must not change while waiting.
- S_WAIT: `mem_resp_valid` → latch `inst` = err ? `NOP_INST` : `mem_resp_data`, `inst_fault` = err, then go to S_OUT.
- S_OUT: `inst_valid`=1; `inst`, `pc`, `inst_fault` are stable. On `inst_ready`:
  - `pc` ← `next_pc`.
  - If `next_pc[1:0]` != 0: no memory request; `inst` ← `NOP_INST`, `inst_fault` ← 1, stay in S_OUT with the new `pc`.
  - Otherwise → S_REQ.
- Only one request is outstanding at a time. `mem_resp_valid` outside S_WAIT is ignored and flagged by an assertion.
- Reset: `pc` = `RESET_PC`, state = S_REQ, `inst` = `NOP_INST`, `inst_fault`=0, `inst_valid`=0, `mem_req_valid`=0. Both request outputs are gated by `!reset`. The memory shares `reset`, so a request interrupted by reset produces no stale response.
- `RESET_PC` is word-aligned by construction; `next_pc` + arithmetic is done by the core, full 32-bit and wrapping.

## Timing
- Reset deasserted before edge 0 → `mem_req_valid`=1 in cycle 0.
- Zero-wait memory (ready in the request cycle, response the next cycle): request cycle N, response N+1, `inst_valid` N+2, `pc` updated at the end of N+2. Throughput is 1 instruction per 3 cycles.
- Each memory stall cycle (`mem_req_ready`=0, or a late response) adds exactly one cycle.
- Outputs in S_OUT are registered. `inst_ready` has no combinational path to the memory outputs; `mem_req_valid` is a decode of the state register only.
- `inst_ready` while `inst_valid`=0 has no effect.
- Reset asserted in any state takes effect at that edge; the next cycle after deassertion is S_REQ at `RESET_PC`.

## Structure
- Shared package `npc_pkg`:
  - `ifu_state_t` enum (S_REQ, S_WAIT, S_OUT).
  - `NPC_RESET_PC` = 32'h80000000.
  - `RV_NOP` = 32'h00000013.
  - `XLEN` = 32.
- Sub-module: the fetch PC register is an instance of the existing `Reg` (width 32, reset value `RESET_PC`), with enable = output handshake.
- `inst`/`inst_fault` capture and the FSM are local. RTL target is about 150 lines.

## Test plan
- Reset release, memory always ready with 1-cycle response, `next_pc` = `pc`+4, `inst_ready`=1: request addresses are 0x80000000, 0x80000004, 0x80000008; `inst_valid` pulses every 3rd cycle starting in cycle 2.
- `mem_req_ready` held low 4 cycles: `mem_req_valid` and `mem_req_addr`=0x80000000 are stable throughout; `inst_valid` is delayed by 4 cycles.
- Back-pressure, `inst_ready` low 5 cycles in S_OUT: `inst`, `pc`, `inst_valid` are stable; no new request is issued.
- Jump: accept with `next_pc`=0x80000100 → next request addr 0x80000100. Accept with `next_pc`=0x80000102 → no request; `inst_valid`=1, `inst_fault`=1, `inst`=0x00000013, `pc`=0x80000102.
- `mem_resp_err`=1 on a fetch → `inst_fault`=1, `inst`=0x00000013; next fetch proceeds from the sampled `next_pc`.
- Reset asserted during S_WAIT and during S_OUT → next cycle after release: `mem_req_valid`=1, addr 0x80000000, `inst_valid`=0.

Source files
------------

// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared npc core types and constants
package npc_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NPC_RESET_PC = 32'h8000_0000;
    localparam logic [XLEN-1:0] RV_NOP       = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } ifu_state_t;

    // Instruction fetches are word-granular; any low address bit set is a fault.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/Reg.sv
// rtl/Reg.sv - generic enabled register with synchronous reset
//   clk    clock
//   rst    synchronous active-high reset, loads RESET_VAL
//   d      next value
//   en     load enable
//   q      register value
module Reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit for the npc single-cycle RV32 core
//   clk, reset       clock, synchronous active-high reset
//   next_pc          next fetch address, sampled on the output handshake
//   inst_ready       core consumes the held instruction
//   inst_valid       inst / pc / inst_fault are valid
//   inst, pc         fetched word and its address
//   inst_fault       bus error or misaligned next_pc (inst is NOP_INST)
//   mem_req_*        read request channel (valid/ready, word address)
//   mem_resp_*       read response channel (valid, data, error)
module ifu
    import npc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = NPC_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INST = RV_NOP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] next_pc,
    input  logic            inst_ready,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic            inst_fault,
    output logic            mem_req_valid,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_req_ready,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,
    input  logic            mem_resp_err
);

    ifu_state_t state;
    logic       accept;

    // Output-side decodes depend only on the state register, never on inst_ready.
    assign inst_valid    = (state == S_OUT) && !reset;
    assign mem_req_valid = (state == S_REQ) && !reset;
    assign mem_req_addr  = reset ? '0 : pc;
    assign accept        = inst_valid && inst_ready;

    Reg #(
        .WIDTH     (XLEN),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk (clk),
        .rst (reset),
        .d   (next_pc),
        .en  (accept),
        .q   (pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_REQ;
            inst       <= NOP_INST;
            inst_fault <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (mem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        inst       <= mem_resp_err ? NOP_INST : mem_resp_data;
                        inst_fault <= mem_resp_err;
                        state      <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (inst_ready) begin
                        // A misaligned target is reported without touching memory:
                        // the fault is presented directly at the new pc.
                        if (is_misaligned(next_pc)) begin
                            inst       <= NOP_INST;
                            inst_fault <= 1'b1;
                        end else begin
                            state <= S_REQ;
                        end
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

    resp_only_when_waiting: assert property (
        @(posedge clk) disable iff (reset) mem_resp_valid |-> (state == S_WAIT)
    );

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - randomized self-checking bench for ifu against a transaction-level model
module tb_ifu;
    import npc_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] next_pc = '0;
    logic        inst_ready = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        inst_fault;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        mem_resp_err = 1'b0;

    ifu dut (
        .clk            (clk),
        .reset          (reset),
        .next_pc        (next_pc),
        .inst_ready     (inst_ready),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .pc             (pc),
        .inst_fault     (inst_fault),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_err   (mem_resp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: fetch address, held word, and where the single outstanding fetch is.
    logic [31:0] m_pc = '0;
    logic [31:0] m_inst = '0;
    logic        m_fault = 1'b0;
    logic        m_need_req = 1'b0;
    logic        m_in_flight = 1'b0;
    logic        m_holding = 1'b0;
    logic        m_known = 1'b0;
    int          m_delay = 0;
    logic        err_sel = 1'b0;
    logic        rand_delay = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e37_79b1) ^ 32'h0f0f_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive the memory response from the model, then compare at the falling edge.
    task automatic sample();
        mem_resp_valid = m_in_flight && (m_delay == 0);
        mem_resp_data  = m_in_flight ? mem_word(m_pc) : $urandom;
        mem_resp_err   = mem_resp_valid && err_sel;
        @(negedge clk);
        if (m_known) begin
            chk("inst_valid", 32'(inst_valid), 32'(m_holding && !reset));
            chk("mem_req_valid", 32'(mem_req_valid), 32'(m_need_req && !reset));
            if (m_need_req && !reset) chk("mem_req_addr", mem_req_addr, m_pc);
            chk("pc", pc, m_pc);
            chk("inst", inst, m_inst);
            chk("inst_fault", 32'(inst_fault), 32'(m_fault));
        end
    endtask

    // Apply this cycle's inputs to the model, then move past the rising edge.
    task automatic advance();
        if (reset) begin
            m_pc        = NPC_RESET_PC;
            m_inst      = RV_NOP;
            m_fault     = 1'b0;
            m_need_req  = 1'b1;
            m_in_flight = 1'b0;
            m_holding   = 1'b0;
            m_known     = 1'b1;
        end else if (m_need_req) begin
            if (mem_req_ready) begin
                m_need_req  = 1'b0;
                m_in_flight = 1'b1;
                m_delay     = rand_delay ? int'($urandom_range(0, 2)) : 0;
            end
        end else if (m_in_flight) begin
            if (m_delay == 0) begin
                m_in_flight = 1'b0;
                m_holding   = 1'b1;
                m_fault     = mem_resp_err;
                m_inst      = mem_resp_err ? RV_NOP : mem_resp_data;
            end else begin
                m_delay--;
            end
        end else if (m_holding && inst_ready) begin
            m_pc = next_pc;
            if (next_pc[1:0] != 2'b00) begin
                m_inst  = RV_NOP;
                m_fault = 1'b1;
            end else begin
                m_holding  = 1'b0;
                m_need_req = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] tmp;
        int r;

        reset = 1'b1;
        sample(); advance();
        sample(); advance();

        // Directed run: zero-wait fetches, stall, back-pressure, jumps, bus error, resets.
        for (int c = 0; c < 31; c++) begin
            reset         = (c == 8) || (c == 26) || (c == 29);
            mem_req_ready = !(c >= 9 && c <= 12);
            inst_ready    = (c <= 8) || (c >= 20);
            err_sel       = (c == 23);
            next_pc       = (c == 20) ? 32'h8000_0102 :
                            (c == 21) ? 32'h8000_0100 :
                            (c == 24) ? 32'h8000_0200 : m_pc + 32'd4;
            sample();
            case (c)
                0: begin
                    chk("lit_c0_req_valid", 32'(mem_req_valid), 32'd1);
                    chk("lit_c0_addr", mem_req_addr, 32'h8000_0000);
                    chk("lit_c0_inst_valid", 32'(inst_valid), 32'd0);
                end
                2: begin
                    chk("lit_c2_inst_valid", 32'(inst_valid), 32'd1);
                    chk("lit_c2_pc", pc, 32'h8000_0000);
                    chk("lit_c2_inst", inst, mem_word(32'h8000_0000));
                end
                3: chk("lit_c3_addr", mem_req_addr, 32'h8000_0004);
                5: chk("lit_c5_inst_valid", 32'(inst_valid), 32'd1);
                6: chk("lit_c6_addr", mem_req_addr, 32'h8000_0008);
                8: chk("lit_c8_pc", pc, 32'h8000_0008);
                9, 12: begin
                    chk("lit_stall_req_valid", 32'(mem_req_valid), 32'd1);
                    chk("lit_stall_addr", mem_req_addr, 32'h8000_0000);
                end
                14: chk("lit_stall_inst_valid_late", 32'(inst_valid), 32'd0);
                15: chk("lit_stall_inst_valid", 32'(inst_valid), 32'd1);
                19: begin
                    chk("lit_bp_inst_valid", 32'(inst_valid), 32'd1);
                    chk("lit_bp_no_req", 32'(mem_req_valid), 32'd0);
                    chk("lit_bp_pc", pc, 32'h8000_0000);
                end
                21: begin
                    chk("lit_mis_valid", 32'(inst_valid), 32'd1);
                    chk("lit_mis_fault", 32'(inst_fault), 32'd1);
                    chk("lit_mis_inst", inst, 32'h0000_0013);
                    chk("lit_mis_pc", pc, 32'h8000_0102);
                    chk("lit_mis_no_req", 32'(mem_req_valid), 32'd0);
                end
                22: chk("lit_jump_addr", mem_req_addr, 32'h8000_0100);
                24: begin
                    chk("lit_err_fault", 32'(inst_fault), 32'd1);
                    chk("lit_err_inst", inst, 32'h0000_0013);
                end
                25: chk("lit_after_err_addr", mem_req_addr, 32'h8000_0200);
                27, 30: begin
                    chk("lit_rst_req_valid", 32'(mem_req_valid), 32'd1);
                    chk("lit_rst_addr", mem_req_addr, 32'h8000_0000);
                    chk("lit_rst_inst_valid", 32'(inst_valid), 32'd0);
                end
                default: ;
            endcase
            advance();
        end

        // Randomized run with variable memory latency.
        rand_delay = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            reset         = ($urandom_range(0, 99) < 2);
            mem_req_ready = ($urandom_range(0, 99) < 70);
            inst_ready    = ($urandom_range(0, 99) < 60);
            err_sel       = ($urandom_range(0, 99) < 10);
            r   = int'($urandom_range(0, 99));
            tmp = $urandom;
            if (r < 70)      next_pc = m_pc + 32'd4;
            else if (r < 85) next_pc = tmp & 32'hffff_fffc;
            else if (r < 95) next_pc = (tmp & 32'hffff_fffc) | 32'($urandom_range(1, 3));
            else             next_pc = 32'hffff_fffc;
            sample();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
